// File: rtl/cheat_pkg.sv
// Shared types for the cheat engine: entry layout, loader states, load status codes.
// Entry fields are held at 32 bits; unused upper bits are zeroed at latch.
package cheat_pkg;

  typedef enum logic [1:0] {
    ADDED    = 2'd0,
    REPLACED = 2'd1,
    TOGGLED  = 2'd2,
    REJECTED = 2'd3
  } load_status_e;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    WRITE
  } loader_state_e;

  localparam int FLAG_COMP = 0;
  localparam int FLAG_MASK = 1;

  typedef struct packed {
    logic        valid;
    logic        en;
    logic        comp_f;
    logic        mask_f;
    logic [31:0] addr;
    logic [31:0] compare;
    logic [31:0] replace;
  } cheat_entry_t;

  function automatic logic [31:0] width_mask(input int w);
    return (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
  endfunction

  // Unpack a loader word {flags, addr, compare, replace}, truncating to the bus widths.
  function automatic cheat_entry_t make_entry(input logic [127:0] code, input int aw, input int dw);
    cheat_entry_t e;
    e.valid   = 1'b1;
    e.en      = 1'b1;
    e.comp_f  = code[96 + FLAG_COMP];
    e.mask_f  = code[96 + FLAG_MASK];
    e.addr    = code[95:64] & width_mask(aw);
    e.compare = code[63:32] & width_mask(dw);
    e.replace = code[31:0]  & width_mask(dw);
    return e;
  endfunction

endpackage

// File: rtl/cheat_match.sv
// Combinational priority matcher over the code table; highest matching index wins.
// Zero latency, no flow control.
module cheat_match
  import cheat_pkg::*;
#(
  parameter int ADDR_WIDTH = 24,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_CODES  = 64
) (
  input  cheat_entry_t          entries [MAX_CODES],
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] data,
  output logic                  hit,
  output logic [DATA_WIDTH-1:0] patched
);

  logic [31:0] a32;
  logic [31:0] d32;
  logic [31:0] res;

  always_comb begin
    a32 = '0;
    d32 = '0;
    a32[ADDR_WIDTH-1:0] = addr;
    d32[DATA_WIDTH-1:0] = data;
    hit = 1'b0;
    res = d32;
    // Ascending scan so a later hit overrides an earlier one.
    for (int i = 0; i < MAX_CODES; i++) begin
      if (entries[i].valid && entries[i].en && entries[i].addr == a32 &&
          (!entries[i].comp_f || entries[i].mask_f || entries[i].compare == d32)) begin
        hit = 1'b1;
        if (entries[i].mask_f)
          res = (d32 & ~entries[i].compare) | (entries[i].replace & entries[i].compare);
        else
          res = entries[i].replace;
      end
    end
    patched = res[DATA_WIDTH-1:0];
  end

endmodule

// File: rtl/cheat_engine_v2.sv
// Cheat code table with valid/ready loader (duplicate scan, toggle/replace/add) and 1-cycle registered read patch.
// Loader accepts only in IDLE, load_done after scan + write; lookup never stalls.
module cheat_engine_v2
  import cheat_pkg::*;
#(
  parameter int ADDR_WIDTH = 24,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_CODES  = 64,
  localparam int IDX_W     = $clog2(MAX_CODES)
) (
  input  logic                  clk,
  input  logic                  cold_reset_n,
  input  logic                  enable,
  input  logic                  clear,
  input  logic                  code_valid,
  output logic                  code_ready,
  input  logic [127:0]          code_in,
  output logic                  load_done,
  output logic [1:0]            load_status,
  output logic [IDX_W:0]        code_count,
  output logic                  codes_full,
  input  logic [ADDR_WIDTH-1:0] addr_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  lookup_ovr,
  output logic [DATA_WIDTH-1:0] lookup_data
);

  loader_state_e state, state_nxt;
  cheat_entry_t  entries [MAX_CODES];
  cheat_entry_t  lat;
  cheat_entry_t  cur;
  cheat_entry_t  hit_ent;
  logic [IDX_W:0]   idx;
  logic [IDX_W-1:0] hit_idx;
  logic             hit_r;
  logic             scan_match;
  logic             same;
  logic             m_hit;
  logic [DATA_WIDTH-1:0] m_data;

  assign code_ready = (state == IDLE);
  assign codes_full = (code_count == (IDX_W+1)'(MAX_CODES));
  assign cur        = entries[idx[IDX_W-1:0]];
  assign hit_ent    = entries[hit_idx];
  assign scan_match = cur.valid && (cur.addr == lat.addr);
  assign same       = (hit_ent.compare == lat.compare) && (hit_ent.replace == lat.replace) &&
                      (hit_ent.comp_f == lat.comp_f) && (hit_ent.mask_f == lat.mask_f);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (code_valid) state_nxt = (code_count == '0) ? WRITE : SCAN;
      SCAN:    if (scan_match || (idx + 1'b1 == code_count)) state_nxt = WRITE;
      WRITE:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (clear) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge cold_reset_n) begin
    if (!cold_reset_n) begin
      state       <= IDLE;
      lat         <= '0;
      idx         <= '0;
      hit_idx     <= '0;
      hit_r       <= 1'b0;
      code_count  <= '0;
      load_done   <= 1'b0;
      load_status <= ADDED;
      for (int i = 0; i < MAX_CODES; i++) entries[i] <= '0;
    end else begin
      state     <= state_nxt;
      load_done <= 1'b0;
      if (clear) begin
        code_count <= '0;
        for (int i = 0; i < MAX_CODES; i++) entries[i].valid <= 1'b0;
      end else begin
        case (state)
          IDLE: if (code_valid) begin
            lat   <= make_entry(code_in, ADDR_WIDTH, DATA_WIDTH);
            idx   <= '0;
            hit_r <= 1'b0;
          end
          SCAN: if (scan_match) begin
            hit_r   <= 1'b1;
            hit_idx <= idx[IDX_W-1:0];
          end else begin
            idx <= idx + 1'b1;
          end
          WRITE: begin
            load_done <= 1'b1;
            if (hit_r && same) begin
              entries[hit_idx].en <= ~hit_ent.en;
              load_status         <= TOGGLED;
            end else if (hit_r) begin
              entries[hit_idx] <= lat;
              load_status      <= REPLACED;
            end else if (codes_full) begin
              load_status <= REJECTED;
            end else begin
              entries[code_count[IDX_W-1:0]] <= lat;
              code_count  <= code_count + 1'b1;
              load_status <= ADDED;
            end
          end
          default: ;
        endcase
      end
    end
  end

  cheat_match #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH),
    .MAX_CODES (MAX_CODES)
  ) u_match (
    .entries(entries),
    .addr   (addr_in),
    .data   (data_in),
    .hit    (m_hit),
    .patched(m_data)
  );

  always_ff @(posedge clk or negedge cold_reset_n) begin
    if (!cold_reset_n) begin
      lookup_ovr  <= 1'b0;
      lookup_data <= '0;
    end else begin
      lookup_ovr  <= enable & m_hit;
      lookup_data <= (enable & m_hit) ? m_data : data_in;
    end
  end

endmodule
